// File: rtl/iter_muldiv_wb.sv
// Iterative unsigned multiply/divide unit that writes its result into the
// register file through the third (write) port after DATA_WIDTH iterations.
module iter_muldiv_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  we3,
  output logic [ADDR_WIDTH-1:0] A3,
  output logic [DATA_WIDTH-1:0] wd3
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  state_t                state;
  logic [CW-1:0]         count;
  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [W-1:0]          divisor_q;
  logic [2*W-1:0]        prod;
  logic [W:0]            rem;
  logic [W-1:0]          quo;

  logic [W:0]     mul_sum;
  logic [2*W-1:0] prod_next;
  logic [W:0]     rem_shift;
  logic [W+1:0]   trial;
  logic [W:0]     rem_next;
  logic [W-1:0]   quo_next;
  logic [W-1:0]   result_next;

  // One iteration of both algorithms; only the one selected by op_q is used
  // for the result. The low half of prod starts as the multiplier and is
  // consumed LSB-first; quo starts as the dividend and is consumed MSB-first.
  always_comb begin
    mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, divisor_q} : {(W+1){1'b0}});
    prod_next = {mul_sum, prod[W-1:1]};

    rem_shift = {rem[W-1:0], quo[W-1]};
    trial     = {1'b0, rem_shift} - {2'b00, divisor_q};
    if (trial[W+1]) begin
      rem_next = rem_shift;
      quo_next = {quo[W-2:0], 1'b0};
    end else begin
      rem_next = trial[W:0];
      quo_next = {quo[W-2:0], 1'b1};
    end

    // A zero divisor never borrows, which yields all-ones / dividend naturally.
    case (op_q)
      2'b00:   result_next = prod_next[W-1:0];
      2'b01:   result_next = prod_next[2*W-1:W];
      2'b10:   result_next = quo_next;
      default: result_next = rem_next[W-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      divisor_q <= '0;
      prod      <= '0;
      rem       <= '0;
      quo       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      we3       <= 1'b0;
      A3        <= '0;
      wd3       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= op;
            rd_q      <= rd_addr;
            divisor_q <= rs2_data;
            prod      <= {{W{1'b0}}, rs1_data};
            quo       <= rs1_data;
            rem       <= '0;
            count     <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          prod <= prod_next;
          rem  <= rem_next;
          quo  <= quo_next;
          if (count == CW'(W - 1)) begin
            count <= '0;
            done  <= 1'b1;
            we3   <= (rd_q != '0);
            A3    <= rd_q;
            wd3   <= result_next;
            state <= WB;
          end else begin
            count <= count + 1'b1;
          end
        end
        WB: begin
          done  <= 1'b0;
          we3   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_muldiv_wb.sv
// Randomised and directed bench for iter_muldiv_wb, checked against a plain
// arithmetic reference model.
module tb_iter_muldiv_wb;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  rs1_data;
  logic [W-1:0]  rs2_data;
  logic [AW-1:0] rd_addr;
  logic          busy;
  logic          done;
  logic          we3;
  logic [AW-1:0] A3;
  logic [W-1:0]  wd3;

  int n_cmp = 0;
  int n_err = 0;

  // observations collected by run_op
  int            obs_lat, obs_busy, obs_done_cnt, obs_we_cnt;
  logic [W-1:0]  obs_wd;
  logic [AW-1:0] obs_a3;
  logic          obs_we;
  logic          post_busy, post_done, post_we;

  iter_muldiv_wb #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .busy(busy), .done(done), .we3(we3), .A3(A3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (o)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called at a negedge. Issues one request, scrambles the inputs after
  // acceptance, and optionally fires extra starts in RUN cycle 5 and in WB.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [AW-1:0] rd, input bit inject);
    op = o; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
    obs_lat = -1; obs_busy = 0; obs_done_cnt = 0; obs_we_cnt = 0;
    obs_wd = '0; obs_a3 = '0; obs_we = 1'b0;
    for (int n = 1; n <= 100 && obs_lat < 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        op = 2'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_addr = AW'($urandom);
      end
      if (inject && n == 5) start = 1'b1;
      if (inject && n == 6) start = 1'b0;
      if (busy) obs_busy++;
      if (we3) obs_we_cnt++;
      if (done) begin
        obs_done_cnt++; obs_lat = n; obs_wd = wd3; obs_a3 = A3; obs_we = we3;
        if (inject) start = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    post_busy = busy; post_done = done; post_we = we3;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = '0; rs1_data = '0; rs2_data = '0; rd_addr = '0;
    #1;
    n_cmp++;
    if ({busy, done, we3, A3, wd3} !== '0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b we3=%b A3=%0d wd3=%h, required all zero", busy, done, we3, A3, wd3);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [1:0]    t_op [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
    logic [W-1:0]  t_a  [8] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'd100, 32'd100, 32'h1234, 32'h1234};
    logic [W-1:0]  t_b  [8] = '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'd7, 32'd7, 32'd0, 32'd0};
    logic [AW-1:0] t_rd [8] = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8};
    logic [W-1:0]  t_ex [8] = '{32'd42, 32'd1, 32'hFFFFFFFE, 32'd1, 32'd14, 32'd2, 32'hFFFFFFFF, 32'h1234};
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], t_rd[i], 1'b0);
      $display("directed %0d: op=%0d a=%h b=%h rd=%0d -> wd3=%h A3=%0d we3=%b lat=%0d", i, t_op[i], t_a[i], t_b[i], t_rd[i], obs_wd, obs_a3, obs_we, obs_lat);
      n_cmp++;
      if (obs_wd !== t_ex[i]) begin n_err++; $display("FAIL directed_wd3[%0d]: got %h required %h", i, obs_wd, t_ex[i]); end
      n_cmp++;
      if (obs_a3 !== t_rd[i] || obs_we !== 1'b1) begin n_err++; $display("FAIL directed_wb[%0d]: A3=%0d we3=%b required A3=%0d we3=1", i, obs_a3, obs_we, t_rd[i]); end
      n_cmp++;
      if (obs_lat != W + 1 || obs_busy != W + 1) begin n_err++; $display("FAIL directed_timing[%0d]: done at %0d busy %0d cycles, required %0d/%0d", i, obs_lat, obs_busy, W + 1, W + 1); end
      n_cmp++;
      if (obs_done_cnt != 1 || obs_we_cnt != 1 || {post_busy, post_done, post_we} !== 3'b000) begin
        n_err++; $display("FAIL directed_pulse[%0d]: dones=%0d wes=%0d after-WB busy/done/we3=%b%b%b, required 1,1,000", i, obs_done_cnt, obs_we_cnt, post_busy, post_done, post_we);
      end
    end
  endtask

  task automatic test_rd_zero;
    run_op(2'd0, 32'd3, 32'd3, 5'd0, 1'b0);
    $display("rd0: MUL 3*3 -> done=%0d we3 pulses=%0d wd3=%h", obs_done_cnt, obs_we_cnt, obs_wd);
    n_cmp++;
    if (obs_done_cnt != 1 || obs_we_cnt != 0 || obs_we !== 1'b0) begin
      n_err++; $display("FAIL rd_zero: dones=%0d we3 pulses=%0d, required 1 and 0", obs_done_cnt, obs_we_cnt);
    end
  endtask

  task automatic test_overlap;
    int extra;
    extra = 0;
    run_op(2'd2, 32'd1000, 32'd33, 5'd9, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || done || we3) extra++;
    end
    $display("overlap: DIVU 1000/33 -> wd3=%h dones=%0d post_busy=%b extra=%0d", obs_wd, obs_done_cnt, post_busy, extra);
    n_cmp++;
    if (obs_wd !== model(2'd2, 32'd1000, 32'd33) || obs_a3 !== 5'd9) begin
      n_err++; $display("FAIL overlap_result: wd3=%h A3=%0d required %h/9", obs_wd, obs_a3, model(2'd2, 32'd1000, 32'd33));
    end
    n_cmp++;
    if (obs_done_cnt != 1 || obs_busy != W + 1 || post_busy !== 1'b0 || extra != 0) begin
      n_err++; $display("FAIL overlap_ignored: dones=%0d busy=%0d post_busy=%b extra=%0d required 1/%0d/0/0", obs_done_cnt, obs_busy, post_busy, extra, W + 1);
    end
  endtask

  task automatic test_back_to_back;
    run_op(2'd0, 32'd11, 32'd13, 5'd10, 1'b0);
    run_op(2'd1, 32'hDEADBEEF, 32'h12345678, 5'd11, 1'b0);
    $display("back_to_back: second MULHU -> wd3=%h lat=%0d", obs_wd, obs_lat);
    n_cmp++;
    if (obs_lat != W + 1 || obs_wd !== model(2'd1, 32'hDEADBEEF, 32'h12345678) || obs_a3 !== 5'd11) begin
      n_err++; $display("FAIL back_to_back: lat=%0d wd3=%h A3=%0d required %0d/%h/11", obs_lat, obs_wd, obs_a3, W + 1, model(2'd1, 32'hDEADBEEF, 32'h12345678));
    end
  endtask

  task automatic test_random;
    logic [1:0]    o;
    logic [W-1:0]  a, b, ex;
    logic [AW-1:0] rd;
    for (int i = 0; i < 40; i++) begin
      o  = 2'($urandom);
      a  = $urandom;
      case ($urandom_range(3))
        0:       b = '0;
        1:       b = W'($urandom_range(255));
        default: b = $urandom;
      endcase
      rd = AW'($urandom);
      ex = model(o, a, b);
      run_op(o, a, b, rd, 1'b0);
      $display("random %0d: op=%0d a=%h b=%h rd=%0d -> wd3=%h expected %h we3=%b", i, o, a, b, rd, obs_wd, ex, obs_we);
      n_cmp++;
      if (obs_wd !== ex || obs_a3 !== rd || obs_we !== (rd != 0) || obs_lat != W + 1) begin
        n_err++; $display("FAIL random[%0d]: wd3=%h A3=%0d we3=%b lat=%0d required %h/%0d/%b/%0d", i, obs_wd, obs_a3, obs_we, obs_lat, ex, rd, rd != 0, W + 1);
      end
    end
  endtask

  task automatic test_reset_run;
    int wes;
    wes = 0;
    op = 2'd2; rs1_data = 32'd50; rs2_data = 32'd5; rd_addr = 5'd3; start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, we3, A3, wd3} !== '0) begin
      n_err++; $display("FAIL reset_mid_run: busy=%b done=%b we3=%b A3=%0d wd3=%h, required all zero", busy, done, we3, A3, wd3);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (we3 || done || busy) wes++;
    end
    n_cmp++;
    if (wes != 0) begin n_err++; $display("FAIL reset_discard: %0d active cycles after reset, required 0", wes); end
    run_op(2'd2, 32'd50, 32'd5, 5'd3, 1'b0);
    $display("reset_run: DIVU 50/5 after reset -> wd3=%h A3=%0d", obs_wd, obs_a3);
    n_cmp++;
    if (obs_wd !== 32'd10 || obs_a3 !== 5'd3 || obs_we !== 1'b1) begin
      n_err++; $display("FAIL reset_recover: wd3=%h A3=%0d we3=%b required 0000000a/3/1", obs_wd, obs_a3, obs_we);
    end
  endtask

  task automatic test_reset_wb;
    bit seen;
    int wes;
    seen = 1'b0; wes = 0;
    op = 2'd0; rs1_data = 32'd5; rs2_data = 32'd5; rd_addr = 5'd4; start = 1'b1;
    for (int n = 1; n <= 100 && !seen; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL reset_wb_reach: done never observed within 100 cycles"); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({we3, done, busy, wd3} !== '0) begin
      n_err++; $display("FAIL reset_in_wb: we3=%b done=%b busy=%b wd3=%h, required all zero", we3, done, busy, wd3);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (we3 || busy) wes++;
    end
    $display("reset_wb: active cycles after reset in WB = %0d", wes);
    n_cmp++;
    if (wes != 0) begin n_err++; $display("FAIL reset_wb_quiet: %0d active cycles, required 0", wes); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_rd_zero;
    test_overlap;
    test_back_to_back;
    test_random;
    test_reset_run;
    test_reset_wb;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
